// File: rtl/hier_node_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// hier_node_pkg: shared types and constants for the hierarchy-node dispatcher.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hier_node_pkg;

  localparam int         NUM_CHILD_DEF = 5;
  localparam int         DATA_W_DEF    = 32;
  localparam logic [2:0] RR_TAG        = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } disp_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [2:0]            dest;
  } disp_item_t;

endpackage

`default_nettype wire

// File: rtl/hier_node_dispatch_if.sv
// ---------------------------------------------------------------------------
// hier_node_dispatch_if: upstream stream plus per-child output channels.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hier_node_dispatch_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_CHILD = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic [2:0]           in_dest;
  logic [NUM_CHILD-1:0] out_valid;
  logic [NUM_CHILD-1:0] out_ready;
  logic [DATA_W-1:0]    out_data;

  modport slave (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/hier_node_dispatch_skid_buf.sv
// ---------------------------------------------------------------------------
// hier_skid_buf: 2-entry fall-through buffer; an empty buffer presents the
// incoming item directly so the output stage can load it in the same cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hier_skid_buf
  import hier_node_pkg::*;
#(
  parameter type ITEM_T = disp_item_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_valid,
  output logic  push_ready,
  input  ITEM_T push_item,
  output logic  head_valid,
  output ITEM_T head_item,
  input  logic  pop
);

  ITEM_T      r_mem [2];
  logic [1:0] r_cnt;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic       w_empty;
  logic       w_write;
  logic       w_read;

  assign w_empty    = (r_cnt == 2'd0);
  assign push_ready = (r_cnt != 2'd2);
  assign head_valid = !w_empty || push_valid;
  assign head_item  = w_empty ? push_item : r_mem[r_rd_ptr];

  // An item popped while the buffer is empty bypasses storage entirely.
  assign w_write = push_valid && push_ready && !(w_empty && pop);
  assign w_read  = pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= push_item;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= !r_wr_ptr;
      if (w_read)  r_rd_ptr <= !r_rd_ptr;
      case ({w_write, w_read})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/hier_node_dispatch.sv
// ---------------------------------------------------------------------------
// hier_node_dispatch: five-way tag/round-robin stream dispatcher with sticky
// drop flag; per-child counters built when HIER_DISPATCH_STATS_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hier_node_dispatch
  import hier_node_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_CHILD = NUM_CHILD_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hier_node_dispatch_if.slave    bus,
  output logic                   drop_err,
  input  logic                   clr_err,
  output logic [16*NUM_CHILD-1:0] stat_cnt
);

  localparam logic [2:0] C_LAST_CHILD = 3'(NUM_CHILD - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        dest;
  } item_t;

  item_t                w_in_item;
  item_t                w_head;
  logic                 w_head_vld;
  disp_state_t          r_state;
  disp_state_t          w_state_nxt;
  logic [NUM_CHILD-1:0] r_out_valid;
  logic [DATA_W-1:0]    r_out_data;
  logic [2:0]           r_rr_ptr;
  logic [2:0]           w_rr_nxt;
  logic                 r_is_rr;
  logic                 r_drop_err;
  logic                 w_hs;
  logic                 w_legal;
  logic [2:0]           w_tgt;
  logic                 w_pop;
  logic                 w_load;
  logic                 w_drop;
  logic                 w_clear;

  assign w_in_item = {bus.in_data, bus.in_dest};

  hier_skid_buf #(.ITEM_T(item_t)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_item  (w_in_item),
    .head_valid (w_head_vld),
    .head_item  (w_head),
    .pop        (w_pop)
  );

  assign w_hs = |(r_out_valid & bus.out_ready);

  // An RR item loaded on the handshake of a previous RR item sees the advanced pointer.
  assign w_rr_nxt = (w_hs && r_is_rr) ? ((r_rr_ptr == C_LAST_CHILD) ? 3'd0 : r_rr_ptr + 3'd1)
                                      : r_rr_ptr;
  assign w_tgt    = (w_head.dest == RR_TAG) ? w_rr_nxt : w_head.dest;
  assign w_legal  = (w_head.dest == RR_TAG) || (w_head.dest <= C_LAST_CHILD);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_head_vld && w_legal) w_state_nxt = HOLD;
      HOLD:    if (w_hs && !(w_head_vld && w_legal)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pop   = 1'b0;
    w_load  = 1'b0;
    w_drop  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop  = w_head_vld;
        w_load = w_head_vld && w_legal;
        w_drop = w_head_vld && !w_legal;
      end
      HOLD: begin
        w_pop   = w_hs && w_head_vld;
        w_load  = w_hs && w_head_vld && w_legal;
        w_drop  = w_hs && w_head_vld && !w_legal;
        w_clear = w_hs && !(w_head_vld && w_legal);
      end
      default: w_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_rr_ptr    <= 3'd0;
      r_is_rr     <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      r_rr_ptr <= w_rr_nxt;
      if (w_load) begin
        r_out_valid <= NUM_CHILD'(1) << w_tgt;
        r_out_data  <= w_head.data;
        r_is_rr     <= (w_head.dest == RR_TAG);
      end else if (w_clear) begin
        r_out_valid <= '0;
        r_is_rr     <= 1'b0;
      end
      if (w_drop)       r_drop_err <= 1'b1;
      else if (clr_err) r_drop_err <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign drop_err      = r_drop_err;

`ifdef HIER_DISPATCH_STATS_EN
  for (genvar i = 0; i < NUM_CHILD; i++) begin : g_stat
    logic [15:0] r_cnt;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= 16'd0;
      end else if (r_out_valid[i] && bus.out_ready[i] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign stat_cnt[16*i +: 16] = r_cnt;
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hier_node_dispatch.sv
// ---------------------------------------------------------------------------
// tb_hier_node_dispatch: table vectors plus directed sequences, scoreboarded.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hier_node_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_err = 1'b0;
  logic        drop_err;
  logic [79:0] stat_cnt;
  logic        mon_en = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  child;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [2:0]  dest;
    logic [31:0] data;
    logic        legal;
    logic [2:0]  child;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[13];

  hier_node_dispatch_if #(.DATA_W(32), .NUM_CHILD(5)) bus ();

  hier_node_dispatch #(.DATA_W(32), .NUM_CHILD(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .drop_err (drop_err),
    .clr_err  (clr_err),
    .stat_cnt (stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en && ((bus.out_valid & bus.out_ready) != 5'd0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got out_valid=%b data=%h, required no delivery",
                 bus.out_valid, bus.out_data);
      end else begin
        mon_e = sb.pop_front();
        check("sb_child", 64'(bus.out_valid), 64'(5'b00001 << mon_e.child));
        check("sb_data", 64'(bus.out_data), 64'(mon_e.data));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the item is taken.
  task automatic push(input logic [2:0] d, input logic [31:0] x, input logic legal,
                      input logic [2:0] ch);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.in_dest  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready=0 for 100 cycles, required 1");
    end else if (legal) begin
      sb.push_back('{child: ch, data: x});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    sb.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h1000_0000, 1'b1, 3'd0};
    vecs[1]  = '{3'd4, 32'h1000_0001, 1'b1, 3'd4};
    vecs[2]  = '{3'd7, 32'h1000_0002, 1'b1, 3'd0};
    vecs[3]  = '{3'd7, 32'h1000_0003, 1'b1, 3'd1};
    vecs[4]  = '{3'd5, 32'h1000_0004, 1'b0, 3'd0};
    vecs[5]  = '{3'd7, 32'h1000_0005, 1'b1, 3'd2};
    vecs[6]  = '{3'd1, 32'h1000_0006, 1'b1, 3'd1};
    vecs[7]  = '{3'd7, 32'h1000_0007, 1'b1, 3'd3};
    vecs[8]  = '{3'd6, 32'h1000_0008, 1'b0, 3'd0};
    vecs[9]  = '{3'd7, 32'h1000_0009, 1'b1, 3'd4};
    vecs[10] = '{3'd7, 32'h1000_000A, 1'b1, 3'd0};
    vecs[11] = '{3'd2, 32'h1000_000B, 1'b1, 3'd2};
    vecs[12] = '{3'd7, 32'h1000_000C, 1'b1, 3'd1};

    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_dest   = 3'd0;
    bus.out_ready = 5'b11111;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_drop_err", 64'(drop_err), 64'd0);
    check("rst_stat_cnt", 64'(stat_cnt[63:0]), 64'd0);
    @(posedge clk);
    #1;

    // Directed: one-cycle latency, single-cycle delivery.
    bus.in_valid = 1'b1;
    bus.in_dest  = 3'd3;
    bus.in_data  = 32'hA5A5_0001;
    sb.push_back('{child: 3'd3, data: 32'hA5A5_0001});
    @(negedge clk);
    check("dir_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("dir_valid", 64'(bus.out_valid), 64'h08);
    check("dir_data", 64'(bus.out_data), 64'hA5A5_0001);
    @(negedge clk);
    check("dir_one_cycle", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      push(vecs[i].dest, vecs[i].data, vecs[i].legal, vecs[i].child);
    end
    drain();
    check("tbl_drop_err", 64'(drop_err), 64'd1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    @(negedge clk);
    check("tbl_clr_err", 64'(drop_err), 64'd0);
    @(posedge clk);
    #1;

    // Clear and a new drop in the same cycle: the drop wins.
    clr_err      = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_dest  = 3'd5;
    bus.in_data  = 32'hE5E5_0005;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    clr_err      = 1'b0;
    @(negedge clk);
    check("ill_clr_and_drop", 64'(drop_err), 64'd1);
    @(posedge clk);
    #1;
    push(3'd0, 32'hE0E0_0000, 1'b1, 3'd0);
    drain();
    check("ill_sticky", 64'(drop_err), 64'd1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    @(negedge clk);
    check("ill_cleared", 64'(drop_err), 64'd0);
    @(posedge clk);
    #1;

    // Backpressure on child 2 with three queued items.
    bus.out_ready = 5'b11011;
    push(3'd2, 32'hB000_0000, 1'b1, 3'd2);
    push(3'd2, 32'hB000_0001, 1'b1, 3'd2);
    push(3'd2, 32'hB000_0002, 1'b1, 3'd2);
    @(negedge clk);
    check("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
    check("bp_hold_valid", 64'(bus.out_valid), 64'h04);
    @(negedge clk);
    check("bp_hold_data", 64'(bus.out_data), 64'hB000_0000);
    @(posedge clk);
    #1;
    bus.out_ready = 5'b11111;
    @(negedge clk);
    check("bp_d0", 64'(bus.out_data), 64'hB000_0000);
    @(negedge clk);
    check("bp_d1", 64'(bus.out_data), 64'hB000_0001);
    check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("bp_d2", 64'(bus.out_data), 64'hB000_0002);
    check("bp_d2_valid", 64'(bus.out_valid), 64'h04);
    @(negedge clk);
    check("bp_idle", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    drain();

    // Reset while one item is held and two are buffered.
    bus.out_ready = 5'b00000;
    push(3'd1, 32'hC000_0000, 1'b0, 3'd1);
    push(3'd1, 32'hC000_0001, 1'b0, 3'd1);
    push(3'd1, 32'hC000_0002, 1'b0, 3'd1);
    @(negedge clk);
    check("mh_held", 64'(bus.out_valid), 64'h02);
    @(posedge clk);
    #1;
    do_reset();
    bus.out_ready = 5'b11111;
    @(negedge clk);
    check("mh_out_valid", 64'(bus.out_valid), 64'd0);
    check("mh_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (5) @(negedge clk);
    check("mh_no_stale", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    push(3'd7, 32'hD000_0000, 1'b1, 3'd0);
    drain();

`ifdef HIER_DISPATCH_STATS_EN
    do_reset();
    mon_en       = 1'b0;
    bus.in_dest  = 3'd1;
    bus.in_data  = 32'h0;
    bus.in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("stat_child1_sat", 64'(stat_cnt[31:16]), 64'hFFFF);
    check("stat_others", {stat_cnt[79:32], stat_cnt[15:0]}, 64'd0);
`else
    check("stat_tied_zero", 64'(stat_cnt[63:0]) | 64'(stat_cnt[79:64]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
